// File: rtl/bin2bcd_conv_pkg.sv
// ---------------------------------------------------------------------------
// bin2bcd_conv_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   - FSM state encoding (IDLE / SHIFT / FINISH)
//   - BCD digit width and the saturation pattern shown on overflow
//   - default widths used by the top-level parameters
// ---------------------------------------------------------------------------
package bin2bcd_conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_NINE = 4'h9;

    // Display word shown when the value needs more digits than the tubes have.
    localparam logic [31:0] SAT_PATTERN = 32'h9999_9999;

    localparam int DEF_IN_W           = 32;
    localparam int DEF_OUT_DIGITS     = 8;
    localparam int DEF_SCRATCH_DIGITS = 10;

endpackage

// File: rtl/bin2bcd_conv_adj.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj
// Combinational add-3 correction for one BCD digit of the double-dabble
// scratch register: a digit of 5 or more gets +3 so that the following
// left shift carries correctly into the next decimal digit.
// Ports:
//   digit : input  [3:0] current scratch digit
//   adj   : output [3:0] corrected digit (digit + 3 if digit >= 5)
// ---------------------------------------------------------------------------
module bcd_digit_adj
    import bin2bcd_conv_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adj
);

    always_comb begin
        adj = digit;
        if (digit >= 4'd5) begin
            adj = digit + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_conv.sv
// ---------------------------------------------------------------------------
// bin2bcd_conv
// Sequential shift-and-add-3 binary-to-BCD converter feeding the seven-
// segment tube driver. One input bit is consumed per clock; the packed BCD
// result is held on bcd_out until the next conversion completes. Results
// needing more than OUT_DIGITS digits saturate to all nines with overflow=1.
//
// Optional feature macro: BIN2BCD_SIGNED_EN
//   defined   : bin_in is two's complement, magnitude is converted, sign on neg
//   undefined : bin_in is unsigned, neg is tied 0, no negate logic
//
// Ports:
//   clk      : input               system clock
//   reset    : input               asynchronous active-high reset
//   start    : input               convert request, sampled only in IDLE
//   bin_in   : input  [IN_W-1:0]   value to convert, captured on accept
//   busy     : output              conversion in progress (SHIFT or FINISH)
//   done     : output              one-cycle pulse when outputs update
//   bcd_out  : output [4*OUT_DIGITS-1:0] packed BCD, digit 0 in [3:0], held
//   overflow : output              last result exceeded OUT_DIGITS, held
//   neg      : output              last input was negative, held
//
// State table:
//   ST_IDLE   | waiting for start; captures bin_in on accept
//   ST_SHIFT  | one add-3 + shift per cycle, IN_W cycles
//   ST_FINISH | saturation check, outputs update, done pulse
// ---------------------------------------------------------------------------
module bin2bcd_conv
    import bin2bcd_conv_pkg::*;
#(
    parameter int IN_W           = DEF_IN_W,
    parameter int OUT_DIGITS     = DEF_OUT_DIGITS,
    parameter int SCRATCH_DIGITS = DEF_SCRATCH_DIGITS
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [IN_W-1:0]                 bin_in,
    output logic                            busy,
    output logic                            done,
    output logic [BCD_DIGIT_W*OUT_DIGITS-1:0] bcd_out,
    output logic                            overflow,
    output logic                            neg
);

    localparam int SCR_W = BCD_DIGIT_W * SCRATCH_DIGITS;
    localparam int OUT_W = BCD_DIGIT_W * OUT_DIGITS;
    localparam int CNT_W = $clog2(IN_W);

    localparam logic [OUT_W-1:0] SAT_WORD =
        (OUT_DIGITS == DEF_OUT_DIGITS) ? OUT_W'(SAT_PATTERN) : {OUT_DIGITS{BCD_NINE}};

    state_t             state_q, state_d;
    logic [IN_W-1:0]    bin_q;
    logic [SCR_W-1:0]   scratch_q;
    logic [SCR_W-1:0]   scratch_adj;
    logic [CNT_W-1:0]   cnt_q;
    logic [IN_W-1:0]    magnitude;
    logic               accept;
    logic               shift_en;
    logic               finish;
    logic               upper_zero;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        shift_en = 1'b0;
        finish   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (cnt_q == CNT_W'(IN_W - 1)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                finish  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------- input capture ----------------
`ifdef BIN2BCD_SIGNED_EN
    logic sign_q;

    // Negating the most negative value wraps to itself, which read as
    // unsigned is exactly its magnitude.
    assign magnitude = bin_in[IN_W-1] ? -bin_in : bin_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign_q <= 1'b0;
        end else if (accept) begin
            sign_q <= bin_in[IN_W-1];
        end
    end
`else
    assign magnitude = bin_in;
`endif

    // ---------------- add-3 correction, one per scratch digit ----------------
    for (genvar g = 0; g < SCRATCH_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adj   (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
        end else if (accept) begin
            bin_q     <= magnitude;
            scratch_q <= '0;
            cnt_q     <= '0;
        end else if (shift_en) begin
            // The scratch register is sized to hold 2^IN_W-1, so the bit
            // shifted out of the top is always zero.
            {scratch_q, bin_q} <= {scratch_adj, bin_q} << 1;
            cnt_q              <= cnt_q + 1'b1;
        end
    end

    assign upper_zero = (scratch_q[SCR_W-1:OUT_W] == '0);

    // ---------------- registered outputs ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            busy <= (state_d != ST_IDLE);
            done <= finish;
            if (finish) begin
                if (upper_zero) begin
                    bcd_out  <= scratch_q[OUT_W-1:0];
                    overflow <= 1'b0;
                end else begin
                    bcd_out  <= SAT_WORD;
                    overflow <= 1'b1;
                end
            end
        end
    end

`ifdef BIN2BCD_SIGNED_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg <= 1'b0;
        end else if (finish) begin
            neg <= sign_q;
        end
    end
`else
    assign neg = 1'b0;
`endif

endmodule

// File: tb/tb_bin2bcd_conv.sv
module tb_bin2bcd_conv;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] bin_in;
    logic        busy;
    logic        done;
    logic [31:0] bcd_out;
    logic        overflow;
    logic        neg;

    int checks = 0;
    int errors = 0;

    bin2bcd_conv #(
        .IN_W           (32),
        .OUT_DIGITS     (8),
        .SCRATCH_DIGITS (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow),
        .neg      (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Counts posedges (sampled #1 after) until done is seen; cyc = edges counted.
    task automatic wait_done(input int max_cyc, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < max_cyc) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Drives start for exactly the accepting edge E0 (block must be IDLE).
    task automatic accept(input logic [31:0] val);
        @(negedge clk);
        start  = 1'b1;
        bin_in = val;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic convert(input string tag, input logic [31:0] val,
                           input logic [31:0] exp_bcd, input logic exp_ovf,
                           input logic exp_neg);
        int cyc;
        bit ok;
        accept(val);
        wait_done(60, cyc, ok);
        chk({tag, "_done_seen"}, 64'(ok), 64'd1);
        chk({tag, "_latency"}, 64'(cyc), 64'd33);
        chk({tag, "_bcd"}, 64'(bcd_out), 64'(exp_bcd));
        chk({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
        chk({tag, "_neg"}, 64'(neg), 64'(exp_neg));
        chk({tag, "_busy_low"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int  cyc;
        int  cyc2;
        bit  ok;
        int  n_done;
        int  done_at;
        bit  busy_ok;
        bit  exp_neg_ff;

        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_bcd", 64'(bcd_out), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_neg", 64'(neg), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Main function and the 8-digit boundary
        convert("c12345", 32'h0000_3039, 32'h0001_2345, 1'b0, 1'b0);
        convert("c99999999", 32'h05F5_E0FF, 32'h9999_9999, 1'b0, 1'b0);
        convert("c1e8", 32'h05F5_E100, 32'h9999_9999, 1'b1, 1'b0);
        convert("c_zero_after_ovf", 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
        convert("c4294", 32'h0000_10C6, 32'h0000_4294, 1'b0, 1'b0);

        // start while busy is ignored; bin_in changes have no effect
        accept(32'h0000_0007);
        n_done  = 0;
        done_at = 0;
        busy_ok = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            start  = (c == 5 || c == 20);
            bin_in = (c == 5 || c == 20) ? 32'h0000_0042 : 32'h0000_0007;
            @(posedge clk);
            #1;
            if (c < 33 && !busy) busy_ok = 1'b0;
            if (done) begin
                n_done++;
                done_at = c;
            end
        end
        start = 1'b0;
        chk("ign_done_count", 64'(n_done), 64'd1);
        chk("ign_done_cycle", 64'(done_at), 64'd33);
        chk("ign_busy_held", 64'(busy_ok), 64'd1);
        chk("ign_bcd", 64'(bcd_out), 64'h7);

        // Reset mid-conversion
        accept(32'h0000_3039);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_bcd", 64'(bcd_out), 64'd0);
        @(negedge clk);
        reset  = 1'b0;
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        chk("abort_no_done", 64'(n_done), 64'd0);
        convert("c123456", 32'h0001_E240, 32'h0012_3456, 1'b0, 1'b0);

        // start held high: back-to-back conversions
        @(negedge clk);
        start  = 1'b1;
        bin_in = 32'h0000_0000;
        wait_done(60, cyc, ok);
        chk("b2b_first_seen", 64'(ok), 64'd1);
        chk("b2b_first_cyc", 64'(cyc), 64'd34);
        chk("b2b_first_bcd", 64'(bcd_out), 64'd0);
        chk("b2b_first_ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        bin_in = 32'hFFFF_FFFF;
        cyc2 = 0;
        ok   = 1'b0;
        // the negedge above is mid-cycle; count the edges from E34 onward
        while (cyc2 < 60) begin
            @(posedge clk);
            #1;
            cyc2++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("b2b_second_seen", 64'(ok), 64'd1);
        chk("b2b_spacing", 64'(cyc2), 64'd34);
`ifdef BIN2BCD_SIGNED_EN
        chk("b2b_second_bcd", 64'(bcd_out), 64'h1);
        chk("b2b_second_ovf", 64'(overflow), 64'd0);
        chk("b2b_second_neg", 64'(neg), 64'd1);
`else
        chk("b2b_second_bcd", 64'(bcd_out), 64'h9999_9999);
        chk("b2b_second_ovf", 64'(overflow), 64'd1);
        chk("b2b_second_neg", 64'(neg), 64'd0);
`endif
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("b2b_idle_after", 64'(busy), 64'd0);

        // Most negative value / top bit set
`ifdef BIN2BCD_SIGNED_EN
        exp_neg_ff = 1'b1;
`else
        exp_neg_ff = 1'b0;
`endif
        convert("c_msb", 32'h8000_0000, 32'h9999_9999, 1'b1, exp_neg_ff);
`ifdef BIN2BCD_SIGNED_EN
        convert("c_neg12345", 32'hFFFF_CFC7, 32'h0001_2345, 1'b0, 1'b1);
        convert("c_pos_after_neg", 32'h0000_0063, 32'h0000_0099, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
